// File: rtl/tinyriscv_pkg.sv
// Shared pipeline-control types: address/hold buses, hold codes and sequencer states.
// Hold codes are numerically ordered so that a larger code implies every smaller one.
package tinyriscv_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int HOLD_FLAG_W = 3;

  typedef logic [INST_ADDR_W-1:0] InstAddrBus;
  typedef logic [HOLD_FLAG_W-1:0] Hold_Flag_Bus;

  localparam Hold_Flag_Bus Hold_None  = 3'd0;
  localparam Hold_Flag_Bus Hold_Pc    = 3'd1;
  localparam Hold_Flag_Bus Hold_If    = 3'd2;
  localparam Hold_Flag_Bus Hold_Id    = 3'd3;
  localparam Hold_Flag_Bus Pipe_Clear = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_hold_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment, holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline sequencer: arbitrates redirects and holds into one hold code, runs the
// post-redirect flush sequence and counts stalled cycles.
module pipe_hold_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   jump_req_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic                   int_jump_i,
  input  logic [INST_ADDR_W-1:0] int_addr_i,
  input  logic                   int_hold_i,
  input  logic                   hold_ex_i,
  input  logic                   hold_bus_i,
  input  logic                   load_use_i,
  input  logic                   perf_clr_i,
  output logic [HOLD_FLAG_W-1:0] hold_flag_o,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam int             FC_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LOAD  = FC_W'(FLUSH_CYC - 1);
  localparam logic            USE_FLUSH = (FLUSH_CYC > 1);

  pipe_ctrl_state_e  state, state_nxt;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_nxt;
  logic [HOLD_FLAG_W-1:0] base_hold;
  logic              redirect;
  logic              stall_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  assign redirect = int_jump_i | jump_req_i;

  always_comb begin
    base_hold = Hold_None;
    if (int_hold_i || hold_ex_i) begin
      base_hold = Hold_Id;
    end else if (hold_bus_i) begin
      base_hold = Hold_Pc;
    end else if (load_use_i) begin
      base_hold = Hold_If;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    hold_flag_o   = Hold_None;
    jump_flag_o   = 1'b0;
    jump_addr_o   = '0;

    if (redirect) begin
      jump_flag_o = 1'b1;
      jump_addr_o = int_jump_i ? int_addr_i : jump_addr_i;
      hold_flag_o = Pipe_Clear;
      if (USE_FLUSH) begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = FC_LOAD;
      end else begin
        state_nxt     = IDLE;
        flush_cnt_nxt = '0;
      end
    end else begin
      case (state)
        FLUSH: begin
          hold_flag_o = Pipe_Clear;
          // Bus stall freezes the flush so the clear is not lost while fetch waits.
          if (!hold_bus_i) begin
            flush_cnt_nxt = flush_cnt - 1'b1;
            if (flush_cnt == FC_W'(1)) begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          hold_flag_o = base_hold;
          state_nxt   = (int_hold_i || hold_ex_i) ? STALL : IDLE;
        end
      endcase
    end

    if (rst_i) begin
      hold_flag_o = Hold_None;
      jump_flag_o = 1'b0;
      jump_addr_o = '0;
    end
  end

  assign stall_en = (hold_flag_o != Hold_None);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .en  (stall_en),
    .clr (perf_clr_i),
    .cnt (stall_cnt_o)
  );

endmodule
